// File: rtl/divisor_segmentado_cfg.sv
// Pipelined restoring divider, signed/unsigned, BPS quotient bits per stage.
// One input stage, WIDTH/BPS iteration stages and one output stage, all advancing together.
module divisor_segmentado_cfg #(
  parameter int WIDTH = 32,
  parameter int BPS   = 1,
  parameter int TAG_W = 4
) (
  input  logic             CLK,
  input  logic             RSTa,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Num,
  input  logic [WIDTH-1:0] Den,
  input  logic             Signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Coc,
  output logic [WIDTH-1:0] Res,
  output logic             div_zero,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int S = WIDTH / BPS;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB_W = {1'b1, {(WIDTH-1){1'b0}}};

  // BPS restoring steps on {acc, q} against m; returns {acc, q}
  function automatic logic [2*WIDTH-1:0] div_steps(input logic [WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] m);
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] qq;
    a  = acc;
    qq = q;
    for (int k = 0; k < BPS; k++) begin
      trial = {a, qq[WIDTH-1]};
      if (trial >= {1'b0, m}) begin
        trial = trial - {1'b0, m};
        qq    = {qq[WIDTH-2:0], 1'b1};
      end else begin
        qq    = {qq[WIDTH-2:0], 1'b0};
      end
      a = trial[WIDTH-1:0];
    end
    return {a, qq};
  endfunction

  // index 0 is the input stage, index i holds the state after i iteration stages
  logic             vld_r  [0:S];
  logic [WIDTH-1:0] acc_r  [0:S];
  logic [WIDTH-1:0] q_r    [0:S];
  logic [WIDTH-1:0] m_r    [0:S];
  logic             sg_r   [0:S];
  logic             nneg_r [0:S];
  logic             dneg_r [0:S];
  logic             dz_r   [0:S];
  logic             ovf_r  [0:S];
  logic [TAG_W-1:0] tag_r  [0:S];

  logic [WIDTH-1:0] acc_nx_s [1:S];
  logic [WIDTH-1:0] q_nx_s   [1:S];

  logic             adv_s;
  logic             num_neg_s;
  logic             den_neg_s;
  logic [WIDTH-1:0] num_abs_s;
  logic [WIDTH-1:0] den_abs_s;
  logic             dz_s;
  logic             ovf_s;
  logic [WIDTH-1:0] coc_nx_s;
  logic [WIDTH-1:0] res_nx_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] coc_r;
  logic [WIDTH-1:0] res_r;
  logic             dz_out_r;
  logic             ovf_out_r;
  logic [TAG_W-1:0] tag_out_r;

  assign adv_s     = out_ready | ~out_valid_r;
  assign in_ready  = adv_s;
  assign out_valid = out_valid_r;
  assign Coc       = coc_r;
  assign Res       = res_r;
  assign div_zero  = dz_out_r;
  assign ovf       = ovf_out_r;
  assign out_tag   = tag_out_r;

  // operand magnitudes and exception detection for the input stage
  always_comb begin
    num_neg_s = Signed & Num[WIDTH-1];
    den_neg_s = Signed & Den[WIDTH-1];
    if (num_neg_s) begin
      num_abs_s = ~Num + ONE_W;
    end else begin
      num_abs_s = Num;
    end
    if (den_neg_s) begin
      den_abs_s = ~Den + ONE_W;
    end else begin
      den_abs_s = Den;
    end
    dz_s  = (Den == {WIDTH{1'b0}});
    ovf_s = Signed & (Num == MSB_W) & (Den == {WIDTH{1'b1}});
  end

  // next {acc, q} for every iteration stage
  always_comb begin
    for (int i = 1; i <= S; i++) begin
      {acc_nx_s[i], q_nx_s[i]} = div_steps(acc_r[i-1], q_r[i-1], m_r[i-1]);
    end
  end

  // sign correction and exception overrides feeding the output stage
  always_comb begin
    if (dz_r[S]) begin
      coc_nx_s = {WIDTH{1'b1}};
    end else if (ovf_r[S]) begin
      coc_nx_s = MSB_W;
    end else if (sg_r[S] && (nneg_r[S] ^ dneg_r[S])) begin
      coc_nx_s = ~q_r[S] + ONE_W;
    end else begin
      coc_nx_s = q_r[S];
    end
    if (ovf_r[S]) begin
      res_nx_s = {WIDTH{1'b0}};
    end else if (sg_r[S] && nneg_r[S]) begin
      res_nx_s = ~acc_r[S] + ONE_W;
    end else begin
      res_nx_s = acc_r[S];
    end
  end

  // pipeline registers: input stage and iteration stages
  always_ff @(posedge CLK) begin
    if (!RSTa) begin
      for (int i = 0; i <= S; i++) begin
        vld_r[i]  <= 1'b0;
        acc_r[i]  <= {WIDTH{1'b0}};
        q_r[i]    <= {WIDTH{1'b0}};
        m_r[i]    <= {WIDTH{1'b0}};
        sg_r[i]   <= 1'b0;
        nneg_r[i] <= 1'b0;
        dneg_r[i] <= 1'b0;
        dz_r[i]   <= 1'b0;
        ovf_r[i]  <= 1'b0;
        tag_r[i]  <= {TAG_W{1'b0}};
      end
    end else if (adv_s) begin
      vld_r[0]  <= in_valid;
      acc_r[0]  <= {WIDTH{1'b0}};
      q_r[0]    <= num_abs_s;
      m_r[0]    <= den_abs_s;
      sg_r[0]   <= Signed;
      nneg_r[0] <= num_neg_s;
      dneg_r[0] <= den_neg_s;
      dz_r[0]   <= dz_s;
      ovf_r[0]  <= ovf_s;
      tag_r[0]  <= in_tag;
      for (int i = 1; i <= S; i++) begin
        vld_r[i]  <= vld_r[i-1];
        acc_r[i]  <= acc_nx_s[i];
        q_r[i]    <= q_nx_s[i];
        m_r[i]    <= m_r[i-1];
        sg_r[i]   <= sg_r[i-1];
        nneg_r[i] <= nneg_r[i-1];
        dneg_r[i] <= dneg_r[i-1];
        dz_r[i]   <= dz_r[i-1];
        ovf_r[i]  <= ovf_r[i-1];
        tag_r[i]  <= tag_r[i-1];
      end
    end
  end

  // output stage register
  always_ff @(posedge CLK) begin
    if (!RSTa) begin
      out_valid_r <= 1'b0;
      coc_r       <= {WIDTH{1'b0}};
      res_r       <= {WIDTH{1'b0}};
      dz_out_r    <= 1'b0;
      ovf_out_r   <= 1'b0;
      tag_out_r   <= {TAG_W{1'b0}};
    end else if (adv_s) begin
      out_valid_r <= vld_r[S];
      coc_r       <= coc_nx_s;
      res_r       <= res_nx_s;
      dz_out_r    <= dz_r[S];
      ovf_out_r   <= ovf_r[S];
      tag_out_r   <= tag_r[S];
    end
  end

endmodule
